// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: RV32 load/store
// func3 encodings, the controller state type and the wait counter width.
package dmem_pkg;

  localparam logic [2:0] LS_B  = 3'b000;
  localparam logic [2:0] LS_H  = 3'b001;
  localparam logic [2:0] LS_W  = 3'b010;
  localparam logic [2:0] LS_BU = 3'b100;
  localparam logic [2:0] LS_HU = 3'b101;

  // Holds WAIT_STATES up to 15.
  localparam int WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

endpackage

// File: rtl/dmem_lane_fmt.sv
// Byte-lane formatting for RV32 loads and stores (purely combinational).
// Produces the store byte mask and lane-replicated write data, and the
// extracted, sign/zero-extended load result from the addressed RAM word.
// Honours DMEM_MISALIGN_ERR_EN: when defined, misaligned H/W and illegal
// func3 are blocked and flagged; otherwise misaligned low bits are ignored.
module dmem_lane_fmt
  import dmem_pkg::*;
(
  input  logic [2:0]  func3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] ram_word,
  output logic [3:0]  wr_mask,
  output logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        acc_err
);

  logic [1:0]  lane;
  logic        legal;
  logic        blocked;
  logic [15:0] shifted;

  // Effective lane, legality and whether the access must be suppressed.
  always_comb begin
    lane    = 2'b00;
    legal   = 1'b1;
    blocked = 1'b0;
    acc_err = 1'b0;
    case (func3)
      LS_B, LS_BU: lane = addr_lo;
      LS_H, LS_HU: lane = {addr_lo[1], 1'b0};
      LS_W:        lane = 2'b00;
      default:     legal = 1'b0;
    endcase
`ifdef DMEM_MISALIGN_ERR_EN
    case (func3)
      LS_H, LS_HU: blocked = addr_lo[0];
      LS_W:        blocked = |addr_lo;
      default:     blocked = 1'b0;
    endcase
    blocked = blocked | ~legal;
    acc_err = blocked;
`else
    blocked = ~legal;
`endif
  end

  // Store mask / write data and load extract / extend.
  always_comb begin
    wr_mask = 4'b0000;
    wr_data = 32'h0;
    rd_data = 32'h0;
    shifted = 16'(ram_word >> {lane, 3'b000});
    if (!blocked) begin
      case (func3)
        LS_B, LS_BU: begin
          wr_mask = 4'b0001 << lane;
          wr_data = {4{wdata[7:0]}};
        end
        LS_H, LS_HU: begin
          wr_mask = 4'b0011 << lane;
          wr_data = {2{wdata[15:0]}};
        end
        LS_W: begin
          wr_mask = 4'b1111;
          wr_data = wdata;
        end
        default: ;
      endcase
      case (func3)
        LS_B:    rd_data = {{24{shifted[7]}}, shifted[7:0]};
        LS_BU:   rd_data = {24'h0, shifted[7:0]};
        LS_H:    rd_data = {{16{shifted[15]}}, shifted[15:0]};
        LS_HU:   rd_data = {16'h0, shifted[15:0]};
        LS_W:    rd_data = ram_word;
        default: rd_data = 32'h0;
      endcase
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the core load/store port: valid/ready request
// and response handshakes, programmable wait states, internal word RAM.
// Optional macro DMEM_MISALIGN_ERR_EN enables rsp_err on misaligned H/W and
// illegal func3; when undefined rsp_err is tied low.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | req_ready=1; a valid request is latched and the access starts
// WAIT  | RAM access cycle plus WAIT_STATES extra cycles; the counter runs
//       | down and at terminal count the store commits / load is read
// RESP  | rsp_valid=1 with stable data/err until rsp_ready
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_func3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  dmem_state_t           state_q, state_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic                  accept;
  logic                  commit;

  logic                  lat_we;
  logic [2:0]            lat_func3;
  logic [AW+1:0]         lat_addr;
  logic [31:0]           lat_wdata;

  logic [31:0]           mem [DEPTH_WORDS];
  logic [31:0]           ram_word;
  logic [3:0]            wr_mask;
  logic [31:0]           wr_data;
  logic [31:0]           rd_data;
  logic                  acc_err;
  logic [31:0]           rdata_q;

  // Upper address bits are don't-care: accesses wrap modulo the RAM size.
  logic                  unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:AW+2];

  assign ram_word  = mem[lat_addr[AW+1:2]];
  assign rsp_rdata = rdata_q;

  dmem_lane_fmt u_lane_fmt (
    .func3    (lat_func3),
    .addr_lo  (lat_addr[1:0]),
    .wdata    (lat_wdata),
    .ram_word (ram_word),
    .wr_mask  (wr_mask),
    .wr_data  (wr_data),
    .rd_data  (rd_data),
    .acc_err  (acc_err)
  );

  // State register and wait down-counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, handshake outputs and access strobes.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    accept    = 1'b0;
    commit    = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept  = 1'b1;
          state_d = WAIT;
          cnt_d   = WAIT_CNT_W'(WAIT_STATES);
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          commit  = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - WAIT_CNT_W'(1);
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request latch, captured on accept and held for the whole transaction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_we    <= 1'b0;
      lat_func3 <= 3'b000;
      lat_addr  <= '0;
      lat_wdata <= 32'h0;
    end else if (accept) begin
      lat_we    <= req_we;
      lat_func3 <= req_func3;
      lat_addr  <= req_addr[AW+1:0];
      lat_wdata <= req_wdata;
    end
  end

  // Response data register; stores always answer with zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q <= 32'h0;
    end else if (commit) begin
      rdata_q <= lat_we ? 32'h0 : rd_data;
    end
  end

`ifdef DMEM_MISALIGN_ERR_EN
  logic err_q;

  // Error flag captured alongside the response data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (commit) begin
      err_q <= acc_err;
    end
  end

  assign rsp_err = err_q;
`else
  logic unused_acc_err;
  assign unused_acc_err = acc_err;
  assign rsp_err        = 1'b0;
`endif

  // RAM byte-lane write at commit; contents survive reset.
  always_ff @(posedge clk) begin
    if (commit && lat_we) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_mask[i]) mem[lat_addr[AW+1:2]][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed vector table, hand-made
// backpressure and mid-transaction reset sequences, then random traffic
// checked against a byte-addressed memory model.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int DEPTH_WORDS = 64;
  localparam int WAIT_STATES = 1;
  localparam int MEM_BYTES   = DEPTH_WORDS * 4;
`ifdef DMEM_MISALIGN_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_func3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;

  byte unsigned mb [MEM_BYTES];

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  dmem_responder #(.DEPTH_WORDS(DEPTH_WORDS), .WAIT_STATES(WAIT_STATES)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_func3 (req_func3),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, got, exp);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s timeout got none want handshake", nm);
  endtask

  // Byte-addressed reference: size/sign from func3, wrap, align or reject.
  function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wd, output logic [31:0] rd, output logic err);
    int size;
    bit sgn;
    int a;
    logic [31:0] v;
    rd = 32'h0; err = 1'b0; sgn = 1'b0; size = 0;
    case (f3)
      3'd0: begin size = 1; sgn = 1'b1; end
      3'd1: begin size = 2; sgn = 1'b1; end
      3'd2: size = 4;
      3'd4: size = 1;
      3'd5: size = 2;
      default: size = 0;
    endcase
    if (size == 0) begin
      err = ERR_EN;
      return;
    end
    a = int'(addr & 32'(MEM_BYTES - 1));
    if (a % size != 0) begin
      if (ERR_EN) begin
        err = 1'b1;
        return;
      end
      a = a - (a % size);
    end
    if (we) begin
      for (int i = 0; i < size; i++) mb[a+i] = wd[8*i +: 8];
    end else begin
      v = 32'h0;
      for (int i = 0; i < size; i++) v[8*i +: 8] = mb[a+i];
      if (sgn && v[8*size-1]) for (int i = size; i < 4; i++) v[8*i +: 8] = 8'hFF;
      rd = v;
    end
  endfunction

  // One full request/response with rsp_ready held high; checks latency.
  task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wd, output logic [31:0] rd, output logic err);
    int t;
    int lat;
    rd = 32'h0; err = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_func3 = f3; req_addr = addr; req_wdata = wd;
    t = 0;
    while (!req_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) begin
      timeout("accept");
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!rsp_valid) begin
      timeout("response");
      return;
    end
    chk("latency", lat, 1 + WAIT_STATES);
    rd  = rsp_rdata;
    err = rsp_err;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] rd, mrd;
    logic        er, mer;
    int          t;

    for (int i = 0; i < MEM_BYTES; i++) mb[i] = 8'h00;

    vecs.push_back('{1'b1, LS_W,  32'h10,  32'hDEADBEEF, 32'h0,        1'b0});
    vecs.push_back('{1'b0, LS_W,  32'h10,  32'h0,        32'hDEADBEEF, 1'b0});
    vecs.push_back('{1'b1, LS_W,  32'h10,  32'h11223344, 32'h0,        1'b0});
    vecs.push_back('{1'b1, LS_B,  32'h13,  32'h000000A5, 32'h0,        1'b0});
    vecs.push_back('{1'b0, LS_W,  32'h10,  32'h0,        32'hA5223344, 1'b0});
    vecs.push_back('{1'b0, LS_B,  32'h13,  32'h0,        32'hFFFFFFA5, 1'b0});
    vecs.push_back('{1'b0, LS_BU, 32'h13,  32'h0,        32'h000000A5, 1'b0});
    vecs.push_back('{1'b1, LS_H,  32'h12,  32'h00008001, 32'h0,        1'b0});
    vecs.push_back('{1'b0, LS_H,  32'h12,  32'h0,        32'hFFFF8001, 1'b0});
    vecs.push_back('{1'b0, LS_HU, 32'h12,  32'h0,        32'h00008001, 1'b0});
    vecs.push_back('{1'b0, LS_H,  32'h10,  32'h0,        32'h00003344, 1'b0});
    vecs.push_back('{1'b0, LS_W,  32'h110, 32'h0,        32'h80013344, 1'b0});
    vecs.push_back('{1'b1, LS_W,  32'h20,  32'hCAFEF00D, 32'h0,        1'b0});
    vecs.push_back('{1'b0, LS_W,  32'h21,  32'h0,        ERR_EN ? 32'h0 : 32'hCAFEF00D, ERR_EN});
    vecs.push_back('{1'b1, 3'b011, 32'h20, 32'hFFFFFFFF, 32'h0,        ERR_EN});
    vecs.push_back('{1'b0, LS_W,  32'h20,  32'h0,        32'hCAFEF00D, 1'b0});
    vecs.push_back('{1'b0, 3'b110, 32'h10, 32'h0,        32'h0,        ERR_EN});
    vecs.push_back('{1'b0, LS_H,  32'h13,  32'h0,        ERR_EN ? 32'h0 : 32'hFFFF8001, ERR_EN});
    vecs.push_back('{1'b0, LS_W,  32'h12,  32'h0,        ERR_EN ? 32'h0 : 32'h80013344, ERR_EN});
    vecs.push_back('{1'b1, LS_W,  32'h20,  32'h0,        32'h0,        1'b0});

    // Reset state.
    @(negedge clk);
    chk("reset req_ready", req_ready, 1);
    chk("reset rsp_valid", rsp_valid, 0);
    chk("reset rsp_rdata", rsp_rdata, 0);
    chk("reset rsp_err",   rsp_err,   0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("idle req_ready", req_ready, 1);

    // Known RAM contents regardless of simulator power-up values.
    for (int w = 0; w < DEPTH_WORDS; w++) xact(1'b1, LS_W, 32'(w * 4), 32'h0, rd, er);

    for (int i = 0; i < vecs.size(); i++) begin
      model(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wd, mrd, mer);
      xact(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wd, rd, er);
      chk($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rd);
      chk($sformatf("vec%0d err", i),   {31'h0, er}, {31'h0, vecs[i].exp_err});
    end

    // Backpressure: response held, a stray store request must be ignored.
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_func3 = LS_W; req_addr = 32'h10; req_wdata = 32'h0;
    chk("bp req_ready idle", req_ready, 1);
    @(posedge clk);
    #1;
    req_we = 1'b1;
    req_wdata = 32'h0;
    t = 0;
    while (!rsp_valid && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (!rsp_valid) timeout("bp response");
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("bp%0d rsp_valid", c), rsp_valid, 1);
      chk($sformatf("bp%0d rsp_rdata", c), rsp_rdata, 32'h80013344);
      chk($sformatf("bp%0d req_ready", c), req_ready, 0);
    end
    @(negedge clk);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp done rsp_valid", rsp_valid, 0);
    chk("bp done req_ready", req_ready, 1);
    xact(1'b0, LS_W, 32'h10, 32'h0, rd, er);
    chk("bp store ignored", rd, 32'h80013344);

    // Reset while a store is waiting: it must never commit.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_func3 = LS_W; req_addr = 32'h20; req_wdata = 32'h12345678;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midreset rsp_valid", rsp_valid, 0);
    chk("midreset rsp_rdata", rsp_rdata, 0);
    chk("midreset rsp_err",   rsp_err,   0);
    chk("midreset req_ready", req_ready, 1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    xact(1'b0, LS_W, 32'h20, 32'h0, rd, er);
    chk("aborted store dropped", rd, 32'h0);

    // Random traffic against the byte-level model.
    for (int n = 0; n < 400; n++) begin
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr, wd;
      we   = 1'($urandom_range(0, 1));
      f3   = 3'($urandom_range(0, 7));
      addr = $urandom();
      wd   = $urandom();
      model(we, f3, addr, wd, mrd, mer);
      xact(we, f3, addr, wd, rd, er);
      chk($sformatf("rnd%0d rdata", n), rd, mrd);
      chk($sformatf("rnd%0d err", n),   {31'h0, er}, {31'h0, mer});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
